hash_nonce_scheduler: RTL and testbench

HASH_NONCE_SCHEDULER -- requirements
Module: hash_nonce_scheduler

---
 rtl/hash_nonce_scheduler.sv | 88 ++++++++
 tb/tb_hash_nonce_scheduler.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/hash_nonce_scheduler.sv
// hash_nonce_scheduler: hands out nonces of one job to a pool of SHA-256 engines and reports completion
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   start                job request, sampled only in IDLE
//   message_addr         job message base, registered and forwarded as eng_msg_addr
//   output_addr          job result base, eng_out_addr = output_addr + nonce
//   busy / done / err    job running, one-cycle completion pulse, sticky spurious-completion flag
//   eng_start            one-hot launch pulse to the lowest-index free engine
//   eng_nonce            nonce for the launched engine
//   eng_msg_addr         registered message base
//   eng_out_addr         result address for the launched nonce
//   eng_done             per-engine completion pulse
module hash_nonce_scheduler #(
  parameter int NUM_ENGINES = 4,
  parameter int NUM_NONCES  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [15:0]            message_addr,
  input  logic [15:0]            output_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [NUM_ENGINES-1:0] eng_start,
  output logic [31:0]            eng_nonce,
  output logic [15:0]            eng_msg_addr,
  output logic [15:0]            eng_out_addr,
  input  logic [NUM_ENGINES-1:0] eng_done
);
  localparam int CW = $clog2(NUM_NONCES + 1);
  typedef enum logic [1:0] {IDLE, DISPATCH, FINISH} state_t;
  state_t                 r_state, w_next;
  logic [15:0]            r_out_base;
  logic [CW-1:0]          r_next_nonce, r_completed, w_completed, w_done_cnt;
  logic [NUM_ENGINES-1:0] r_eng_busy, w_free, w_sel;
  logic                   r_err, w_launch, w_spur;
  assign w_free = ~r_eng_busy;
  // isolate the lowest set bit: lowest-index free engine
  assign w_sel = w_free & (~w_free + NUM_ENGINES'(1));
  assign w_launch = (r_state == DISPATCH) && (r_next_nonce < CW'(NUM_NONCES)) && (|w_free);
  // completions from idle engines are not counted, only flagged
  assign w_spur = |(eng_done & ~r_eng_busy);
  always_comb begin
    w_done_cnt = '0;
    for (int i = 0; i < NUM_ENGINES; i++) w_done_cnt = w_done_cnt + CW'(eng_done[i] & r_eng_busy[i]);
  end
  assign w_completed = r_completed + w_done_cnt;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE)     ? (start ? DISPATCH : IDLE) :
             (r_state == DISPATCH) ? ((w_completed == CW'(NUM_NONCES)) ? FINISH : DISPATCH) :
                                     IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_msg_addr <= '0;
      r_out_base   <= '0;
      r_next_nonce <= '0;
      r_completed  <= '0;
      r_eng_busy   <= '0;
      r_err        <= 1'b0;
    end else if (r_state == IDLE && start) begin
      eng_msg_addr <= message_addr;
      r_out_base   <= output_addr;
      r_next_nonce <= '0;
      r_completed  <= '0;
      r_eng_busy   <= '0;
      r_err        <= 1'b0;
    end else if (r_state == DISPATCH) begin
      // a freed engine only becomes eligible next cycle because w_sel reads the registered bits
      r_eng_busy   <= (r_eng_busy & ~eng_done) | eng_start;
      r_next_nonce <= r_next_nonce + CW'(w_launch);
      r_completed  <= w_completed;
      r_err        <= r_err | w_spur;
    end
  end
  assign busy         = (r_state == DISPATCH);
  assign done         = (r_state == FINISH);
  assign err          = r_err;
  assign eng_start    = w_launch ? w_sel : '0;
  assign eng_nonce    = w_launch ? 32'(r_next_nonce) : '0;
  assign eng_out_addr = w_launch ? r_out_base + 16'(r_next_nonce) : '0;
endmodule

// File: tb/tb_hash_nonce_scheduler.sv
// tb_hash_nonce_scheduler: table-driven jobs against an engine model and a launch scoreboard
module tb_hash_nonce_scheduler;
  localparam int NE = 4;
  localparam int NN = 16;
  logic          clk = 1'b0;
  logic          reset, start;
  logic [15:0]   message_addr, output_addr;
  logic          busy, done, err;
  logic [NE-1:0] eng_start, eng_done;
  logic [31:0]   eng_nonce;
  logic [15:0]   eng_msg_addr, eng_out_addr;
  int            tests = 0;
  int            fails = 0;
  always #5 clk = ~clk;
  hash_nonce_scheduler #(.NUM_ENGINES(NE), .NUM_NONCES(NN)) dut (
    .clk(clk), .reset(reset), .start(start), .message_addr(message_addr), .output_addr(output_addr),
    .busy(busy), .done(done), .err(err), .eng_start(eng_start), .eng_nonce(eng_nonce),
    .eng_msg_addr(eng_msg_addr), .eng_out_addr(eng_out_addr), .eng_done(eng_done)
  );
  typedef struct {
    logic [15:0] oa;
    logic [15:0] ma;
    int          lat;
    logic [15:0] last_oa;
    int          spur;
    bit          hold;
    int          abort;
    bit          sim;
  } vec_t;
  typedef struct {
    logic [31:0] nonce;
    logic [15:0] addr;
  } exp_t;
  exp_t sbq[$];
  vec_t vecs[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_eng_start"}, eng_start, 0);
    chk({tag, "_eng_nonce"}, eng_nonce, 0);
    chk({tag, "_eng_msg_addr"}, eng_msg_addr, 0);
    chk({tag, "_eng_out_addr"}, eng_out_addr, 0);
  endtask
  task automatic run_job(input vec_t v);
    int            cnt[NE];
    int            issued, comp, seen;
    bit            merr, done_seen;
    logic [NE-1:0] exp_start, dv;
    exp_t          e;
    foreach (cnt[k]) cnt[k] = 0;
    issued = 0; comp = 0; seen = 0; merr = 1'b0; done_seen = 1'b0;
    sbq.delete();
    for (int n = 0; n < NN; n++) begin
      e.nonce = 32'(n);
      e.addr  = v.oa + 16'(n);
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b1; message_addr = v.ma; output_addr = v.oa; eng_done = '0;
    @(posedge clk); #1;
    if (!v.hold) start = 1'b0;
    message_addr = ~v.ma;
    output_addr  = ~v.oa;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("err", err, merr);
      chk("eng_msg_addr", eng_msg_addr, v.ma);
      chk("done", done, comp == NN);
      chk("busy", busy, comp != NN);
      if (comp == NN) begin
        done_seen = 1'b1;
        eng_done = '0;
        break;
      end
      exp_start = '0;
      if (issued < NN)
        for (int k = NE - 1; k >= 0; k--) if (cnt[k] == 0) exp_start = NE'(1) << k;
      chk("eng_start", eng_start, exp_start);
      if (eng_start != '0) begin
        seen++;
        if (sbq.size() == 0) chk("sb_underflow", eng_nonce, 32'hFFFF_FFFF);
        else begin
          e = sbq.pop_front();
          chk("eng_nonce", eng_nonce, e.nonce);
          chk("eng_out_addr", eng_out_addr, e.addr);
          if (e.nonce == 32'(NN - 1)) chk("last_out_addr", eng_out_addr, v.last_oa);
        end
      end
      dv = '0;
      for (int k = 0; k < NE; k++)
        if (cnt[k] > 0) begin
          cnt[k]--;
          if (cnt[k] == 0) begin
            dv[k] = 1'b1;
            comp++;
          end
        end
      if (cyc == v.spur && cnt[3] == 0 && !dv[3] && !exp_start[3]) begin
        dv[3] = 1'b1;
        merr = 1'b1;
      end
      for (int k = 0; k < NE; k++)
        if (exp_start[k]) begin
          cnt[k] = (v.sim && k == 1) ? v.lat - 1 : v.lat;
          issued++;
        end
      eng_done = dv;
      if (v.abort != 0 && issued == v.abort) begin
        #2 reset = 1'b1;
        #1 chk_all_zero("async_reset");
        eng_done = '0;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
          chk("post_reset_done", done, 0);
          chk("post_reset_eng_start", eng_start, 0);
          @(posedge clk); #1;
        end
        return;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    eng_done = '0;
    chk("job_done_seen", done_seen, 1);
    chk("launch_count", seen, NN);
    chk("scoreboard_empty", sbq.size(), 0);
  endtask
  initial begin
    vecs[0] = '{oa: 16'h0100, ma: 16'h1234, lat: 70, last_oa: 16'h010F, spur: -1, hold: 0, abort: 0, sim: 0};
    vecs[1] = '{oa: 16'hFFF8, ma: 16'hABCD, lat: 3,  last_oa: 16'h0007, spur: 2,  hold: 0, abort: 0, sim: 0};
    vecs[2] = '{oa: 16'h0000, ma: 16'h0001, lat: 1,  last_oa: 16'h000F, spur: -1, hold: 1, abort: 0, sim: 0};
    vecs[3] = '{oa: 16'h2000, ma: 16'h5555, lat: 4,  last_oa: 16'h200F, spur: -1, hold: 0, abort: 5, sim: 0};
    vecs[4] = '{oa: 16'h0100, ma: 16'h0F0F, lat: 5,  last_oa: 16'h010F, spur: -1, hold: 0, abort: 0, sim: 0};
    vecs[5] = '{oa: 16'h0300, ma: 16'hBEEF, lat: 6,  last_oa: 16'h030F, spur: -1, hold: 0, abort: 0, sim: 1};
    reset = 1'b1; start = 1'b0; eng_done = '0; message_addr = '0; output_addr = '0;
    #2 chk_all_zero("reset_state");
    @(posedge clk); #1;
    reset = 1'b0;
    for (int r = 0; r < 6; r++) run_job(vecs[r]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
